// File: rtl/vector_writeback_pkg.sv
// Shared vector definitions: widths, instruction codes, writeback FSM states.
// Imported by the execute stage and the writeback block.
package vector_writeback_pkg;

  localparam int VWB_VLEN_BITS = 128;
  localparam int VWB_BUS_BITS  = 4 * VWB_VLEN_BITS;

  typedef enum logic [2:0] {
    VXOR     = 3'b000,
    VMACC    = 3'b001,
    VREDSUM  = 3'b010,
    VSLIDEUP = 3'b011,
    VRGATHER = 3'b100,
    VINVALID = 3'b111
  } vinst_e;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/vector_writeback_strobe_gen.sv
// Byte-enable generator for register-file writes.
// Ports: inst_i (instruction), sew_i (element width) -> strb_o (byte enables).
module vwb_strobe_gen
  import vector_writeback_pkg::*;
#(
  parameter int VLEN_BITS = VWB_VLEN_BITS
) (
  input  logic [2:0]             inst_i,
  input  logic                   sew_i,
  output logic [VLEN_BITS/8-1:0] strb_o
);

  // A reduction only produces element 0: one byte at SEW=8, two at SEW=16.
  always_comb begin
    strb_o = '1;
    if (inst_i == VREDSUM) begin
      strb_o    = '0;
      strb_o[0] = 1'b1;
      strb_o[1] = sew_i;
    end
  end

endmodule

// File: rtl/vector_writeback.sv
// Vector writeback: accepts one execute result and writes it to the VRF
// in 1 or 4 beats. Ports: wb_* result handshake, vrf_* write port, wb_done/wb_err pulses.
module vector_writeback
  import vector_writeback_pkg::*;
#(
  parameter int VLEN_BITS = VWB_VLEN_BITS,
  parameter int BUS_BITS  = VWB_BUS_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [BUS_BITS-1:0]    wb_data,
  input  logic [2:0]             wb_inst,
  input  logic [4:0]             wb_vd,
  input  logic                   wb_lmul,
  input  logic                   wb_sew,
  output logic                   vrf_we,
  output logic [4:0]             vrf_waddr,
  output logic [VLEN_BITS-1:0]   vrf_wdata,
  output logic [VLEN_BITS/8-1:0] vrf_wstrb,
  input  logic                   vrf_wready,
  output logic                   wb_done,
  output logic                   wb_err
);

  wb_state_e           state_q;
  logic [1:0]          beat_q;
  logic [1:0]          last_q;
  logic [BUS_BITS-1:0] data_q;
  logic [2:0]          inst_q;
  logic [4:0]          vd_q;
  logic                sew_q;
  logic                done_q;
  logic                err_q;
  logic                accept;
  logic                illegal;
  logic [VLEN_BITS-1:0] lane [4];

  assign wb_ready = (state_q == IDLE);
  assign accept   = wb_valid && wb_ready;
  assign illegal  = (wb_inst == VINVALID) ||
                    (wb_lmul && (wb_vd[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      inst_q  <= '0;
      vd_q    <= '0;
      sew_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            data_q <= wb_data;
            inst_q <= wb_inst;
            vd_q   <= wb_vd;
            sew_q  <= wb_sew;
            beat_q <= '0;
            // Reductions yield a single register even for a group.
            last_q <= (wb_lmul && wb_inst != VREDSUM) ? 2'd3 : 2'd0;
            if (illegal) err_q   <= 1'b1;
            else         state_q <= WRITE;
          end
        end
        WRITE: begin
          if (vrf_wready) begin
            if (beat_q == last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = data_q[i*VLEN_BITS +: VLEN_BITS];
  end

  // Group base is a multiple of 4, so vd + beat never exceeds 31.
  assign vrf_we    = (state_q == WRITE);
  assign vrf_waddr = vd_q + {3'b000, beat_q};
  assign vrf_wdata = lane[beat_q];
  assign wb_done   = done_q;
  assign wb_err    = err_q;

  vwb_strobe_gen #(
    .VLEN_BITS (VLEN_BITS)
  ) u_strobe (
    .inst_i (inst_q),
    .sew_i  (sew_q),
    .strb_o (vrf_wstrb)
  );

endmodule

// File: tb/tb_vector_writeback.sv
// Self-checking bench for vector_writeback: directed scenarios followed by
// randomized results checked against a transaction-level reference model.
module tb_vector_writeback;

  localparam int VL = 128;
  localparam int BB = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid;
  logic          wb_ready;
  logic [BB-1:0] wb_data;
  logic [2:0]    wb_inst;
  logic [4:0]    wb_vd;
  logic          wb_lmul;
  logic          wb_sew;
  logic          vrf_we;
  logic [4:0]    vrf_waddr;
  logic [VL-1:0] vrf_wdata;
  logic [VL/8-1:0] vrf_wstrb;
  logic          vrf_wready;
  logic          wb_done;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_inst    (wb_inst),
    .wb_vd      (wb_vd),
    .wb_lmul    (wb_lmul),
    .wb_sew     (wb_sew),
    .vrf_we     (vrf_we),
    .vrf_waddr  (vrf_waddr),
    .vrf_wdata  (vrf_wdata),
    .vrf_wstrb  (vrf_wstrb),
    .vrf_wready (vrf_wready),
    .wb_done    (wb_done),
    .wb_err     (wb_err)
  );

  task automatic chk(input string tag, input logic [VL-1:0] obs,
                     input logic [VL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BB-1:0] rand_bus();
    logic [BB-1:0] v;
    for (int i = 0; i < BB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic scramble_inputs();
    wb_data = rand_bus();
    wb_inst = 3'($urandom);
    wb_vd   = 5'($urandom);
    wb_lmul = 1'($urandom);
    wb_sew  = 1'($urandom);
  endtask

  task automatic chk_beat(input string tag, input logic [4:0] addr,
                          input logic [VL-1:0] data, input logic [15:0] strb);
    chk({tag, ".we"},    VL'(vrf_we),    VL'(1));
    chk({tag, ".addr"},  VL'(vrf_waddr), VL'(addr));
    chk({tag, ".data"},  vrf_wdata,      data);
    chk({tag, ".strb"},  VL'(vrf_wstrb), VL'(strb));
    chk({tag, ".ready"}, VL'(wb_ready),  VL'(0));
  endtask

  // Reference model: a result either errors out or expands to a list of
  // (vd+k, slice k, strobe) beats, followed by one done pulse.
  task automatic send(input logic [2:0] inst, input logic [4:0] vd,
                      input logic lmul, input logic sew,
                      input logic [BB-1:0] data, input int stall_beat,
                      input int stall_cyc, input int rst_beat);
    bit        ill;
    int        n;
    int        w;
    int        st;
    logic [15:0] es;
    ill = (inst == 3'b111) || (lmul && vd[1:0] != 2'b00);
    n   = (inst == 3'b010) ? 1 : (lmul ? 4 : 1);
    es  = (inst == 3'b010) ? (sew ? 16'h0003 : 16'h0001) : 16'hFFFF;
    w = 0;
    while (!wb_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("wait_ready", VL'(wb_ready), VL'(1));
    wb_valid   = 1'b1;
    wb_inst    = inst;
    wb_vd      = vd;
    wb_lmul    = lmul;
    wb_sew     = sew;
    wb_data    = data;
    vrf_wready = 1'($urandom);
    @(negedge clk);
    wb_valid = 1'b0;
    scramble_inputs();
    if (ill) begin
      chk("ill.err",   VL'(wb_err),   VL'(1));
      chk("ill.we",    VL'(vrf_we),   VL'(0));
      chk("ill.ready", VL'(wb_ready), VL'(1));
      chk("ill.done",  VL'(wb_done),  VL'(0));
      @(negedge clk);
      chk("ill.err_pulse", VL'(wb_err), VL'(0));
      chk("ill.we2",       VL'(vrf_we), VL'(0));
      return;
    end
    for (int k = 0; k < n; k++) begin
      st = (k == stall_beat) ? stall_cyc : 0;
      for (int s = 0; s < st; s++) begin
        vrf_wready = 1'b0;
        chk_beat("stall", vd + 5'(k), data[k*VL +: VL], es);
        chk("stall.done", VL'(wb_done), VL'(0));
        scramble_inputs();
        @(negedge clk);
      end
      if (k == rst_beat) begin
        vrf_wready = 1'b0;
        chk_beat("pre_rst", vd + 5'(k), data[k*VL +: VL], es);
        #2 rst = 1'b1;
        #1;
        chk("rst.we_async", VL'(vrf_we),  VL'(0));
        chk("rst.done",     VL'(wb_done), VL'(0));
        chk("rst.err",      VL'(wb_err),  VL'(0));
        @(negedge clk);
        rst = 1'b0;
        vrf_wready = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("post_rst.we",    VL'(vrf_we),   VL'(0));
          chk("post_rst.done",  VL'(wb_done),  VL'(0));
          chk("post_rst.ready", VL'(wb_ready), VL'(1));
        end
        return;
      end
      vrf_wready = 1'b1;
      chk_beat("beat", vd + 5'(k), data[k*VL +: VL], es);
      chk("beat.done", VL'(wb_done), VL'(0));
      chk("beat.err",  VL'(wb_err),  VL'(0));
      @(negedge clk);
    end
    vrf_wready = 1'($urandom);
    chk("done.pulse", VL'(wb_done),  VL'(1));
    chk("done.err",   VL'(wb_err),   VL'(0));
    chk("done.we",    VL'(vrf_we),   VL'(0));
    chk("done.ready", VL'(wb_ready), VL'(1));
    @(negedge clk);
    chk("done.once",  VL'(wb_done),  VL'(0));
  endtask

  initial begin
    logic [2:0] ops [6];
    logic [2:0] op;
    logic [4:0] vd;
    logic       lm;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    ops[3] = 3'b011; ops[4] = 3'b100; ops[5] = 3'b111;
    rst        = 1'b1;
    wb_valid   = 1'b0;
    vrf_wready = 1'b1;
    scramble_inputs();
    #1;
    chk("reset.we",   VL'(vrf_we),  VL'(0));
    chk("reset.done", VL'(wb_done), VL'(0));
    chk("reset.err",  VL'(wb_err),  VL'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready", VL'(wb_ready), VL'(1));
    chk("reset.we2",   VL'(vrf_we),   VL'(0));

    send(3'b000, 5'd5,  1'b0, 1'b0, rand_bus(), -1, 0, -1);
    send(3'b001, 5'd8,  1'b1, 1'b0, rand_bus(), 1, 2, -1);
    send(3'b010, 5'd12, 1'b1, 1'b1, rand_bus(), -1, 0, -1);
    send(3'b010, 5'd7,  1'b0, 1'b0, rand_bus(), 0, 1, -1);
    send(3'b000, 5'd6,  1'b1, 1'b0, rand_bus(), -1, 0, -1);
    send(3'b111, 5'd4,  1'b0, 1'b0, rand_bus(), -1, 0, -1);
    send(3'b100, 5'd28, 1'b1, 1'b0, rand_bus(), 3, 1, -1);
    send(3'b001, 5'd16, 1'b1, 1'b0, rand_bus(), -1, 0, 2);
    send(3'b011, 5'd3,  1'b0, 1'b0, rand_bus(), -1, 0, -1);

    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(0, 5)];
      lm = 1'($urandom);
      vd = 5'($urandom);
      if (lm && $urandom_range(0, 9) < 7) vd[1:0] = 2'b00;
      send(op, vd, lm, 1'($urandom), rand_bus(),
           $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_writeback.md
VECTOR_WRITEBACK -- requirements
Module: vector_writeback

Interface
REQ-001 SHALL have parameter VLEN_BITS, default 128, meaning vector register width and width of one write beat.
REQ-002 SHALL have parameter BUS_BITS, default 512, meaning result bus width (4 x VLEN_BITS).
REQ-003 SHALL have ports, in order:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- wb_valid  in  1  result offered.
- wb_ready  out  1  block can accept a result.
- wb_data  in  BUS_BITS  result bus from the execute stage.
- wb_inst  in  3  instruction type; same encoding as the execute stage's cur_inst.
- wb_vd  in  5  destination register index.
- wb_lmul  in  1  0: one register; 1: four-register group.
- wb_sew  in  1  0: 8-bit elements; 1: 16-bit elements.
- vrf_we  out  1  register-file write request.
- vrf_waddr  out  5  register-file write index.
- vrf_wdata  out  VLEN_BITS  write data.
- vrf_wstrb  out  VLEN_BITS/8  byte enables.
- vrf_wready  in  1  register file accepts the current beat.
- wb_done  out  1  one-cycle pulse when a result is retired.
- wb_err  out  1  one-cycle pulse when a result is dropped as illegal.

Function
REQ-004 SHALL implement FSM states IDLE and WRITE; wb_ready = (state == IDLE).
REQ-005 SHALL accept a result on clk when wb_valid && wb_ready, capturing wb_data, wb_inst, wb_vd, wb_lmul and wb_sew into internal registers. Later input changes SHALL NOT affect the transfer in progress.
REQ-006 SHALL classify the accepted result as illegal when wb_inst == 3'b111, or when wb_lmul == 1 and wb_vd[1:0] != 0.
- Illegal result: no write, state stays IDLE, wb_err = 1 in the next cycle.
- Legal result: state moves to WRITE with beat counter = 0.
REQ-007 SHALL set the beat count to 4 when lmul == 1, else 1. Exception: vredsum (3'b010) always uses 1 beat.
REQ-008 SHALL, in WRITE, drive the following; beat k takes effect when vrf_wready is high:
- vrf_we = 1.
- vrf_waddr = vd + k.
- vrf_wdata = wb_data[k*VLEN_BITS +: VLEN_BITS].
REQ-009 SHALL hold vrf_we, vrf_waddr, vrf_wdata and vrf_wstrb stable while vrf_we && !vrf_wready.
REQ-010 SHALL drive vrf_wstrb as follows:
- All ones for every instruction except vredsum.
- For vredsum: 16'h0001 when sew == 0, 16'h0003 when sew == 1 (element 0 only).
REQ-011 SHALL, on the last beat handshake, return to IDLE and pulse wb_done = 1 in the following cycle.
REQ-012 SHALL deliver the first beat in the cycle after acceptance. Minimum occupancy is 1 + beats cycles, giving one idle cycle between back-to-back results.
REQ-013 SHALL drive vrf_we = 0 in IDLE; vrf_waddr, vrf_wdata and vrf_wstrb are don't-care whenever vrf_we = 0.
REQ-014 SHALL compute vd + k without wrap. Legal lmul = 1 indices are multiples of 4, so the maximum index is 31.
REQ-015 SHALL never assert wb_done and wb_err in the same cycle.

Reset
REQ-016 SHALL, on rst high, immediately force the following regardless of clk:
- state = IDLE, beat counter = 0.
- vrf_we = 0, wb_done = 0, wb_err = 0.
- wb_ready = 1 from the first clk after deassertion.
REQ-017 SHALL abandon a transfer interrupted by reset mid-WRITE: no further beats and no wb_done.

Structure
REQ-018 SHALL take instruction codes (VXOR 000, VMACC 001, VREDSUM 010, VSLIDEUP 011, VRGATHER 100, INVALID 111), VLEN_BITS and BUS_BITS from the shared vector package used by the execute stage.
REQ-019 SHALL place strobe generation (inst, sew -> vrf_wstrb) in one combinational sub-module, vwb_strobe_gen.

Verification
REQ-020 SHALL cover the following directed scenarios:
- VXOR, lmul = 0, vd = 5, vrf_wready = 1: one beat, waddr 5, wdata = wb_data[127:0], wstrb 16'hFFFF, wb_done in the next cycle.
- VMACC, lmul = 1, vd = 8, vrf_wready low for 2 cycles on beat 1: beats to addr 8, 9, 10, 11 in order; beat 1 held stable while stalled; one wb_done.
- VREDSUM, lmul = 1, sew = 1, vd = 12: exactly one beat, waddr 12, wstrb 16'h0003.
- lmul = 1 with vd = 6, and separately inst = 3'b111: no vrf_we, one wb_err pulse, wb_ready stays 1.
- rst asserted during beat 2 of a 4-beat write: vrf_we drops asynchronously, no wb_done; the next result, VSLIDEUP with lmul = 0 and vd = 3, writes addr 3 correctly.
